// File: rtl/sd_boot_loader.sv
// Boot-time copy engine: reads N_BLOCKS SD blocks through sdspihost and writes them as
// little-endian 32-bit words over a Wishbone B3 classic master, holding cpu_rst until done.
`timescale 1ns/1ps
module sd_boot_loader #(
  parameter logic [31:0] BASE_BLOCK     = 32'd0,
  parameter logic [15:0] N_BLOCKS       = 16'd64,
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int          RST_CYCLES     = 16,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        start,
  output logic        busy_o,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic        cpu_rst,
  output logic        spi_rst,
  output logic        spi_r_block,
  output logic        spi_r_byte,
  output logic [31:0] spi_block_addr,
  input  logic        spi_busy,
  input  logic        spi_err,
  input  logic [7:0]  spi_dat_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic [2:0]  wbm_cti_o,
  output logic [1:0]  wbm_bte_o,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_SPI_RST, S_WAIT_INIT, S_BLK_REQ, S_BLK_WAIT, S_BYTE_REQ,
    S_BYTE_WAIT, S_WB_WRITE, S_NEXT_BLK, S_DONE, S_ERROR
  } state_t;

  state_t      r_state;
  logic [23:0] r_tmo;
  logic [15:0] r_blk;
  logic [8:0]  r_byte_cnt;
  logic [23:0] r_word;
  logic        r_seen;
  logic        r_busy, r_done, r_error, r_cpu_rst, r_spi_rst, r_r_block, r_r_byte, r_cyc;
  logic [1:0]  r_err_code;
  logic [31:0] r_blk_addr, r_adr, r_dat;

  logic        w_active;
  logic [1:0]  w_err_code;
  logic [15:0] w_blk_inc;

  assign w_blk_inc = r_blk + 16'd1;

  // Error sources in priority order: SD host, Wishbone slave, then per-state timeout.
  always_comb begin
    w_active   = !(r_state inside {S_IDLE, S_DONE, S_ERROR});
    w_err_code = 2'd0;
    if (w_active && spi_err)                                 w_err_code = 2'd1;
    else if (r_cyc && wbm_err_i)                             w_err_code = 2'd3;
    else if (w_active && r_tmo == TIMEOUT_CYCLES - 24'd1)    w_err_code = 2'd2;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state    <= S_IDLE;
      r_tmo      <= '0;
      r_blk      <= '0;
      r_byte_cnt <= '0;
      r_word     <= '0;
      r_seen     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'd0;
      r_cpu_rst  <= 1'b1;
      r_spi_rst  <= 1'b1;
      r_r_block  <= 1'b0;
      r_r_byte   <= 1'b0;
      r_cyc      <= 1'b0;
      r_blk_addr <= '0;
      r_adr      <= '0;
      r_dat      <= '0;
    end else begin
      r_r_byte <= 1'b0;
      r_tmo    <= r_tmo + 24'd1;
      if (w_err_code != 2'd0) begin
        r_state    <= S_ERROR;
        r_error    <= 1'b1;
        r_err_code <= w_err_code;
        r_cpu_rst  <= 1'b1;
        r_spi_rst  <= 1'b1;
        r_r_block  <= 1'b0;
        r_cyc      <= 1'b0;
        r_busy     <= 1'b0;
        r_tmo      <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE, S_ERROR: if (start) begin
            r_state    <= S_SPI_RST;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= 2'd0;
            r_cpu_rst  <= 1'b1;
            r_spi_rst  <= 1'b1;
            r_tmo      <= '0;
            r_blk      <= '0;
            r_byte_cnt <= '0;
            r_adr      <= MEM_BASE;
            r_seen     <= 1'b0;
          end
          S_SPI_RST: if (r_tmo == 24'(RST_CYCLES - 1)) begin
            r_state   <= S_WAIT_INIT;
            r_spi_rst <= 1'b0;
            r_tmo     <= '0;
          end
          S_WAIT_INIT: if (!spi_busy) begin
            r_state    <= S_BLK_REQ;
            r_r_block  <= 1'b1;
            r_blk_addr <= BASE_BLOCK + {16'd0, r_blk};
            r_tmo      <= '0;
          end
          S_BLK_REQ: begin
            r_state <= S_BLK_WAIT;
            r_seen  <= 1'b0;
            r_tmo   <= '0;
          end
          // Busy must be seen high before its fall counts as completion.
          S_BLK_WAIT:
            if (!r_seen) r_seen <= spi_busy;
            else if (!spi_busy) begin
              r_state  <= S_BYTE_REQ;
              r_r_byte <= 1'b1;
              r_tmo    <= '0;
            end
          S_BYTE_REQ: begin
            r_state <= S_BYTE_WAIT;
            r_seen  <= 1'b0;
            r_tmo   <= '0;
          end
          S_BYTE_WAIT:
            if (!r_seen) r_seen <= spi_busy;
            else if (!spi_busy) begin
              r_byte_cnt <= r_byte_cnt + 9'd1;
              r_tmo      <= '0;
              if (r_byte_cnt[1:0] == 2'd3) begin
                r_state <= S_WB_WRITE;
                r_cyc   <= 1'b1;
                r_dat   <= {spi_dat_o, r_word[23:0]};
              end else begin
                r_word[{r_byte_cnt[1:0], 3'b000} +: 8] <= spi_dat_o;
                r_state  <= S_BYTE_REQ;
                r_r_byte <= 1'b1;
              end
            end
          S_WB_WRITE: if (wbm_ack_i) begin
            r_cyc <= 1'b0;
            r_adr <= r_adr + 32'd4;
            r_tmo <= '0;
            if (r_byte_cnt == 9'd0) begin
              r_state   <= S_NEXT_BLK;
              r_r_block <= 1'b0;
            end else begin
              r_state  <= S_BYTE_REQ;
              r_r_byte <= 1'b1;
            end
          end
          S_NEXT_BLK: begin
            r_blk <= w_blk_inc;
            r_tmo <= '0;
            if (w_blk_inc == N_BLOCKS) begin
              r_state   <= S_DONE;
              r_done    <= 1'b1;
              r_busy    <= 1'b0;
              r_cpu_rst <= 1'b0;
              r_spi_rst <= 1'b0;
            end else begin
              r_state    <= S_BLK_REQ;
              r_r_block  <= 1'b1;
              r_blk_addr <= BASE_BLOCK + {16'd0, w_blk_inc};
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy_o         = r_busy;
  assign done           = r_done;
  assign error          = r_error;
  assign err_code       = r_err_code;
  assign cpu_rst        = r_cpu_rst;
  assign spi_rst        = r_spi_rst;
  assign spi_r_block    = r_r_block;
  assign spi_r_byte     = r_r_byte;
  assign spi_block_addr = r_blk_addr;
  assign wbm_adr_o      = r_adr;
  assign wbm_dat_o      = r_dat;
  assign wbm_sel_o      = 4'hF;
  assign wbm_we_o       = r_cyc;
  assign wbm_cyc_o      = r_cyc;
  assign wbm_stb_o      = r_cyc;
  assign wbm_cti_o      = 3'b000;
  assign wbm_bte_o      = 2'b00;

endmodule
